// File: rtl/egress_pkt_arbiter_pkg.sv
// rtl/egress_pkt_arbiter_pkg.sv - shared constants, tags and FSM encoding for the egress arbiter
// Purpose: word width, packet tag encodings, default FIFO geometry and the arbiter state type.
// Ports: none (package).
package egress_pkt_arbiter_pkg;

  localparam int PKT_W         = 134;
  localparam int DEF_PKT_AW    = 8;
  localparam int DEF_VAL_AW    = 5;
  localparam int DEF_AF_MARGIN = 32;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

  // A head-only packet carries the tail tag, so this alone marks end of packet.
  function automatic logic is_tail(input logic [PKT_W-1:0] word);
    return word[PKT_W-1 -: 2] == TAG_TAIL;
  endfunction

endpackage

// File: rtl/egress_pkt_if.sv
// rtl/egress_pkt_if.sv - packet word + descriptor stream bundle with backpressure
// Purpose: groups one packet stream (words, descriptor, almostfull) between producer and consumer.
// Ports (modport master = producer): pkt_wr, pkt[133:0], valid_wr, valid out; pkt_almostfull in.
//       (modport slave  = consumer): the same signals in the opposite direction.
interface egress_pkt_if;
  import egress_pkt_arbiter_pkg::*;

  logic             pkt_wr;
  logic [PKT_W-1:0] pkt;
  logic             valid_wr;
  logic             valid;
  logic             pkt_almostfull;

  modport master (output pkt_wr, pkt, valid_wr, valid, input  pkt_almostfull);
  modport slave  (input  pkt_wr, pkt, valid_wr, valid, output pkt_almostfull);
endinterface

// File: rtl/egress_arb_port_fifo.sv
// rtl/egress_arb_port_fifo.sv - per-port packet word FIFO plus descriptor FIFO with almostfull
// Purpose: buffers one input port; a descriptor entry marks a complete packet ready to arbitrate.
// Ports: i_clk, i_rst_n (async active-low); i_pkt_wr/i_pkt, i_valid_wr/i_valid write side;
//        i_pkt_rd -> o_pkt/o_pkt_empty and i_valid_rd -> o_valid/o_valid_empty (show-ahead read);
//        o_almostfull registered backpressure.
module egress_arb_port_fifo
  import egress_pkt_arbiter_pkg::*;
#(
  parameter int PKT_AW    = DEF_PKT_AW,
  parameter int VAL_AW    = DEF_VAL_AW,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pkt_wr,
  input  logic [PKT_W-1:0] i_pkt,
  input  logic             i_valid_wr,
  input  logic             i_valid,
  input  logic             i_pkt_rd,
  output logic [PKT_W-1:0] o_pkt,
  output logic             o_pkt_empty,
  input  logic             i_valid_rd,
  output logic             o_valid,
  output logic             o_valid_empty,
  output logic             o_almostfull
);
  localparam logic [PKT_AW:0] PKT_FULL = (PKT_AW+1)'(2**PKT_AW);
  localparam logic [PKT_AW:0] PKT_AF   = (PKT_AW+1)'(2**PKT_AW - AF_MARGIN);
  localparam logic [PKT_AW:0] PKT_ONE  = (PKT_AW+1)'(1);
  localparam logic [VAL_AW:0] VAL_FULL = (VAL_AW+1)'(2**VAL_AW);
  localparam logic [VAL_AW:0] VAL_AF   = (VAL_AW+1)'(2**VAL_AW - 2);
  localparam logic [VAL_AW:0] VAL_ONE  = (VAL_AW+1)'(1);

  logic [PKT_W-1:0]  r_pmem [2**PKT_AW];
  logic              r_vmem [2**VAL_AW];
  logic [PKT_AW-1:0] r_pwr_ptr, r_prd_ptr;
  logic [VAL_AW-1:0] r_vwr_ptr, r_vrd_ptr;
  logic [PKT_AW:0]   r_pcnt, w_pcnt_nxt;
  logic [VAL_AW:0]   r_vcnt, w_vcnt_nxt;
  logic              w_pwe, w_pre, w_vwe, w_vre;
  logic              r_af, r_overflow;

  always_comb begin
    w_pwe = i_pkt_wr && (r_pcnt != PKT_FULL);
    w_pre = i_pkt_rd && (r_pcnt != '0);
    w_vwe = i_valid_wr && (r_vcnt != VAL_FULL);
    w_vre = i_valid_rd && (r_vcnt != '0);
    w_pcnt_nxt = r_pcnt;
    if (w_pwe && !w_pre)      w_pcnt_nxt = r_pcnt + PKT_ONE;
    else if (!w_pwe && w_pre) w_pcnt_nxt = r_pcnt - PKT_ONE;
    w_vcnt_nxt = r_vcnt;
    if (w_vwe && !w_vre)      w_vcnt_nxt = r_vcnt + VAL_ONE;
    else if (!w_vwe && w_vre) w_vcnt_nxt = r_vcnt - VAL_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (w_pwe) r_pmem[r_pwr_ptr] <= i_pkt;
    if (w_vwe) r_vmem[r_vwr_ptr] <= i_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwr_ptr  <= '0;
      r_prd_ptr  <= '0;
      r_vwr_ptr  <= '0;
      r_vrd_ptr  <= '0;
      r_pcnt     <= '0;
      r_vcnt     <= '0;
      r_af       <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pwe) r_pwr_ptr <= r_pwr_ptr + PKT_AW'(1);
      if (w_pre) r_prd_ptr <= r_prd_ptr + PKT_AW'(1);
      if (w_vwe) r_vwr_ptr <= r_vwr_ptr + VAL_AW'(1);
      if (w_vre) r_vrd_ptr <= r_vrd_ptr + VAL_AW'(1);
      r_pcnt <= w_pcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      // Built from next-state counts so the flag lines up with the count it describes.
      r_af <= (w_pcnt_nxt >= PKT_AF) || (w_vcnt_nxt >= VAL_AF);
      r_overflow <= r_overflow || (i_pkt_wr && !w_pwe) || (i_valid_wr && !w_vwe);
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !r_overflow);

  assign o_pkt         = r_pmem[r_prd_ptr];
  assign o_pkt_empty   = (r_pcnt == '0);
  assign o_valid       = r_vmem[r_vrd_ptr];
  assign o_valid_empty = (r_vcnt == '0);
  assign o_almostfull  = r_af;
endmodule

// File: rtl/egress_pkt_arbiter.sv
// rtl/egress_pkt_arbiter.sv - two-port packet-granular round-robin egress arbiter
// Purpose: merges the TDMA stream (port 0) and CPU stream (port 1) into one egress stream,
//          whole packets at a time; packets with a 0 descriptor are discarded.
// Ports: i_clk, i_rst_n (async active-low); i_in0, i_in1 input streams (slave);
//        o_out egress stream (master), its pkt_almostfull is the downstream backpressure.
module egress_pkt_arbiter
  import egress_pkt_arbiter_pkg::*;
#(
  parameter int PKT_AW    = DEF_PKT_AW,
  parameter int VAL_AW    = DEF_VAL_AW,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  egress_pkt_if.slave  i_in0,
  egress_pkt_if.slave  i_in1,
  egress_pkt_if.master o_out
);
  logic [PKT_W-1:0] w_pkt0, w_pkt1, w_word;
  logic w_pempty0, w_pempty1, w_vempty0, w_vempty1, w_v0, w_v1;
  logic w_prd0, w_prd1, w_vrd0, w_vrd1;
  logic w_start, w_gnt_nxt, w_desc, w_word_ok, w_busy;

  state_t           r_state;
  logic             r_gnt, r_prio;
  logic             r_pkt_wr, r_valid_wr, r_valid;
  logic [PKT_W-1:0] r_pkt;

  egress_arb_port_fifo #(.PKT_AW(PKT_AW), .VAL_AW(VAL_AW), .AF_MARGIN(AF_MARGIN)) u_fifo0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pkt_wr(i_in0.pkt_wr), .i_pkt(i_in0.pkt), .i_valid_wr(i_in0.valid_wr), .i_valid(i_in0.valid),
    .i_pkt_rd(w_prd0), .o_pkt(w_pkt0), .o_pkt_empty(w_pempty0),
    .i_valid_rd(w_vrd0), .o_valid(w_v0), .o_valid_empty(w_vempty0),
    .o_almostfull(i_in0.pkt_almostfull)
  );

  egress_arb_port_fifo #(.PKT_AW(PKT_AW), .VAL_AW(VAL_AW), .AF_MARGIN(AF_MARGIN)) u_fifo1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pkt_wr(i_in1.pkt_wr), .i_pkt(i_in1.pkt), .i_valid_wr(i_in1.valid_wr), .i_valid(i_in1.valid),
    .i_pkt_rd(w_prd1), .o_pkt(w_pkt1), .o_pkt_empty(w_pempty1),
    .i_valid_rd(w_vrd1), .o_valid(w_v1), .o_valid_empty(w_vempty1),
    .o_almostfull(i_in1.pkt_almostfull)
  );

  always_comb begin
    // r_prio names the port that wins a tie; a lone eligible port always wins.
    w_gnt_nxt = r_prio;
    if (!(!w_vempty0 && !w_vempty1)) w_gnt_nxt = !w_vempty1;
    w_start   = (r_state == IDLE) && (!w_vempty0 || !w_vempty1) && !o_out.pkt_almostfull;
    w_vrd0    = w_start && !w_gnt_nxt;
    w_vrd1    = w_start && w_gnt_nxt;
    w_desc    = w_gnt_nxt ? w_v1 : w_v0;
    w_busy    = (r_state == SEND) || (r_state == DROP);
    w_word_ok = r_gnt ? !w_pempty1 : !w_pempty0;
    w_prd0    = w_busy && !r_gnt && !w_pempty0;
    w_prd1    = w_busy && r_gnt && !w_pempty1;
    w_word    = r_gnt ? w_pkt1 : w_pkt0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_prio     <= 1'b0;
      r_pkt_wr   <= 1'b0;
      r_pkt      <= '0;
      r_valid_wr <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_pkt_wr   <= 1'b0;
      r_valid_wr <= 1'b0;
      r_valid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_gnt   <= w_gnt_nxt;
            r_state <= w_desc ? SEND : DROP;
          end
        end
        SEND: begin
          if (w_word_ok) begin
            r_pkt_wr <= 1'b1;
            r_pkt    <= w_word;
            if (is_tail(w_word)) begin
              r_valid_wr <= 1'b1;
              r_valid    <= 1'b1;
              r_prio     <= !r_gnt;
              r_state    <= IDLE;
            end
          end
        end
        DROP: begin
          if (w_word_ok && is_tail(w_word)) begin
            r_prio  <= !r_gnt;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_out.pkt_wr   = r_pkt_wr;
  assign o_out.pkt      = r_pkt;
  assign o_out.valid_wr = r_valid_wr;
  assign o_out.valid    = r_valid;
endmodule

// File: tb/tb_egress_pkt_arbiter.sv
// tb/tb_egress_pkt_arbiter.sv - self-checking bench for egress_pkt_arbiter
module tb_egress_pkt_arbiter;
  import egress_pkt_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  egress_pkt_if u_in0 ();
  egress_pkt_if u_in1 ();
  egress_pkt_if u_out ();

  egress_pkt_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in0(u_in0), .i_in1(u_in1), .o_out(u_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int vwr_cnt = 0;
  int vwr_bad = 0;
  logic [PKT_W-1:0] cap_q[$];
  int               cap_cyc[$];
  logic [PKT_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_out.pkt_wr) begin
        cap_q.push_back(u_out.pkt);
        cap_cyc.push_back(cyc);
      end
      if (u_out.valid_wr) begin
        vwr_cnt++;
        if (!(u_out.pkt_wr && u_out.pkt[PKT_W-1 -: 2] == 2'b10 && u_out.valid)) vwr_bad++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [PKT_W-1:0] mk_word(int port, int id, int idx, int n);
    logic [1:0] tag;
    logic [3:0] inv;
    tag = (idx == n-1) ? 2'b10 : ((idx == 0) ? 2'b01 : 2'b11);
    inv = (idx == n-1) ? 4'h5 : 4'h0;
    return {tag, inv, 104'h0, 8'(port), 8'(id), 8'(idx)};
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic wr, input logic [PKT_W-1:0] w,
                       input logic vwr, input logic v);
    if (port == 0) begin
      u_in0.pkt_wr = wr; u_in0.pkt = w; u_in0.valid_wr = vwr; u_in0.valid = v;
    end else begin
      u_in1.pkt_wr = wr; u_in1.pkt = w; u_in1.valid_wr = vwr; u_in1.valid = v;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
    vwr_cnt = 0;
    vwr_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    clear_cap();
  endtask

  // Called just after a rising edge; returns the bench cycle at which the tail was presented.
  task automatic send_pkt(input int port, input int id, input int n, input logic vld, output int tail_cyc);
    tail_cyc = 0;
    for (int i = 0; i < n; i++) begin
      drive(port, 1'b1, mk_word(port, id, i, n), (i == n-1), (i == n-1) ? vld : 1'b0);
      if (i == n-1) tail_cyc = cyc;
      wait_cyc(1);
    end
    drive(port, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic cmp_queue(input string name);
    chk_i({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk_w($sformatf("%s_word%0d", name, i), cap_q[i], exp_q[i]);
  endtask

  typedef struct {
    int   port;
    int   n;
    logic vld;
    int   exp_words;
    int   exp_vwr;
  } vec_t;

  vec_t vecs[6];
  int   sz0[3];
  int   sz1[3];
  int   k;
  int   bad_gap;
  int   seen;
  int   n_before;

  initial begin
    vecs[0] = '{0, 4, 1'b1, 4, 1};
    vecs[1] = '{1, 4, 1'b1, 4, 1};
    vecs[2] = '{0, 1, 1'b1, 1, 1};
    vecs[3] = '{1, 1, 1'b0, 0, 0};
    vecs[4] = '{0, 3, 1'b0, 0, 0};
    vecs[5] = '{1, 2, 1'b1, 2, 1};
    sz0 = '{2, 3, 1};
    sz1 = '{4, 1, 2};

    u_out.pkt_almostfull = 1'b0;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    wait_cyc(2);
    chk_i("rst_pkt_wr", int'(u_out.pkt_wr), 0);
    chk_i("rst_valid_wr", int'(u_out.valid_wr), 0);
    chk_i("rst_valid", int'(u_out.valid), 0);
    chk_w("rst_pkt", u_out.pkt, '0);
    chk_i("rst_af0", int'(u_in0.pkt_almostfull), 0);
    chk_i("rst_af1", int'(u_in1.pkt_almostfull), 0);
    rst_n = 1'b1;
    wait_cyc(1);

    // Single-packet vectors: content, descriptor strobe, drop behaviour, first-word latency.
    for (int v = 0; v < 6; v++) begin
      clear_cap();
      send_pkt(vecs[v].port, v, vecs[v].n, vecs[v].vld, k);
      wait_cyc(15);
      for (int i = 0; i < vecs[v].exp_words; i++)
        exp_q.push_back(mk_word(vecs[v].port, v, i, vecs[v].n));
      cmp_queue($sformatf("vec%0d", v));
      chk_i($sformatf("vec%0d_vwr", v), vwr_cnt, vecs[v].exp_vwr);
      chk_i($sformatf("vec%0d_vwr_tail", v), vwr_bad, 0);
      if (vecs[v].exp_words > 0 && cap_cyc.size() > 0)
        chk_i($sformatf("vec%0d_latency", v), cap_cyc[0], k + 3);
    end

    // Round robin over three packets per port, released together.
    do_reset();
    u_out.pkt_almostfull = 1'b1;
    for (int i = 0; i < 3; i++) send_pkt(0, 10 + i, sz0[i], 1'b1, k);
    for (int i = 0; i < 3; i++) send_pkt(1, 20 + i, sz1[i], 1'b1, k);
    wait_cyc(3);
    chk_i("rr_held", cap_q.size(), 0);
    u_out.pkt_almostfull = 1'b0;
    wait_cyc(40);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < sz0[i]; j++) exp_q.push_back(mk_word(0, 10 + i, j, sz0[i]));
      for (int j = 0; j < sz1[i]; j++) exp_q.push_back(mk_word(1, 20 + i, j, sz1[i]));
    end
    cmp_queue("rr");
    chk_i("rr_vwr", vwr_cnt, 6);
    chk_i("rr_vwr_tail", vwr_bad, 0);
    bad_gap = 0;
    for (int i = 0; i + 1 < cap_q.size(); i++) begin
      if (cap_q[i][PKT_W-1 -: 2] == 2'b10) begin
        if (cap_cyc[i+1] - cap_cyc[i] != 2) bad_gap++;
      end else if (cap_cyc[i+1] - cap_cyc[i] != 1) bad_gap++;
    end
    chk_i("rr_gap", bad_gap, 0);

    // Discarded packet between two forwarded ones.
    do_reset();
    u_out.pkt_almostfull = 1'b1;
    send_pkt(0, 30, 3, 1'b1, k);
    send_pkt(1, 31, 2, 1'b0, k);
    send_pkt(0, 32, 2, 1'b1, k);
    u_out.pkt_almostfull = 1'b0;
    wait_cyc(30);
    for (int j = 0; j < 3; j++) exp_q.push_back(mk_word(0, 30, j, 3));
    for (int j = 0; j < 2; j++) exp_q.push_back(mk_word(0, 32, j, 2));
    cmp_queue("drop");
    chk_i("drop_vwr", vwr_cnt, 2);

    // Downstream backpressure: blocks a start, ignored once a packet is under way.
    do_reset();
    u_out.pkt_almostfull = 1'b1;
    send_pkt(0, 40, 4, 1'b1, k);
    wait_cyc(10);
    chk_i("bp_blocked", cap_q.size(), 0);
    u_out.pkt_almostfull = 1'b0;
    seen = 0;
    for (int t = 0; t < 20 && seen == 0; t++) begin
      wait_cyc(1);
      if (u_out.pkt_wr) seen = 1;
    end
    chk_i("bp_started", seen, 1);
    u_out.pkt_almostfull = 1'b1;
    wait_cyc(15);
    for (int j = 0; j < 4; j++) exp_q.push_back(mk_word(0, 40, j, 4));
    cmp_queue("bp");
    chk_i("bp_vwr", vwr_cnt, 1);
    u_out.pkt_almostfull = 1'b0;

    // Port0 almostfull threshold at 224 words.
    do_reset();
    u_out.pkt_almostfull = 1'b1;
    for (int i = 0; i < 224; i++) begin
      drive(0, 1'b1, mk_word(0, 50, i, 224), (i == 223), 1'b1);
      wait_cyc(1);
      if (i == 222) chk_i("af0_223", int'(u_in0.pkt_almostfull), 0);
      if (i == 223) begin
        chk_i("af0_224", int'(u_in0.pkt_almostfull), 1);
        chk_i("af1_quiet", int'(u_in1.pkt_almostfull), 0);
      end
    end
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    u_out.pkt_almostfull = 1'b0;
    wait_cyc(240);
    chk_i("af0_drained", int'(u_in0.pkt_almostfull), 0);
    for (int j = 0; j < 224; j++) exp_q.push_back(mk_word(0, 50, j, 224));
    cmp_queue("af");
    chk_i("af_vwr", vwr_cnt, 1);

    // Reset during word 2 of a 5-word packet.
    do_reset();
    send_pkt(0, 60, 5, 1'b1, k);
    seen = 0;
    for (int t = 0; t < 20 && seen < 2; t++) begin
      wait_cyc(1);
      if (u_out.pkt_wr) seen++;
    end
    chk_i("mid_rst_reached", seen, 2);
    rst_n = 1'b0;
    #1;
    chk_i("mid_rst_pkt_wr", int'(u_out.pkt_wr), 0);
    chk_i("mid_rst_valid_wr", int'(u_out.valid_wr), 0);
    chk_w("mid_rst_pkt", u_out.pkt, '0);
    n_before = cap_q.size();
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(15);
    chk_i("mid_rst_no_residue", cap_q.size(), n_before);
    chk_i("mid_rst_no_vwr", vwr_cnt, 0);
    clear_cap();
    send_pkt(0, 61, 2, 1'b1, k);
    wait_cyc(15);
    for (int j = 0; j < 2; j++) exp_q.push_back(mk_word(0, 61, j, 2));
    cmp_queue("post_rst");
    chk_i("post_rst_vwr", vwr_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
